// File: rtl/sd_cmd_pkg.sv
// Shared types and widths for the SD-host command scheduler slice.
package sd_cmd_pkg;

  localparam int CMD_INDEX_W = 6;
  localparam int CMD_ARG_W   = 32;
  localparam int RESP_W      = 128;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    GAP,
    DONE
  } sched_state_t;

endpackage

// File: rtl/cmd_rr_arbiter.sv
// Two-way round-robin arbiter; on a tie the requester that did not win last time is granted.
module cmd_rr_arbiter (
  input  logic [1:0] valid,
  input  logic       last_grant,
  input  logic       enable,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (enable) begin
      grant[0] = valid[0] & (~valid[1] | last_grant);
      grant[1] = valid[1] & (~valid[0] | ~last_grant);
    end
  end

endmodule

// File: rtl/cmd_scheduler.sv
// Shares the SD command controller between the register interface (port 0) and the
// data engine (port 1): arbitration, issue, response timeout with retries, completion.
module cmd_scheduler
  import sd_cmd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int MAX_RETRIES    = 2,
  parameter int CNT_W          = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   req0_valid,
  input  logic [CMD_INDEX_W-1:0] req0_index,
  input  logic [CMD_ARG_W-1:0]   req0_argument,
  output logic                   req0_ready,
  input  logic                   req1_valid,
  input  logic [CMD_INDEX_W-1:0] req1_index,
  input  logic [CMD_ARG_W-1:0]   req1_argument,
  output logic                   req1_ready,
  input  logic                   timeout_en,
  output logic                   done0,
  output logic                   done1,
  output logic [RESP_W-1:0]      resp_data,
  output logic                   resp_error,
  output logic                   resp_timeout,
  output logic                   new_command,
  output logic [CMD_INDEX_W-1:0] cmd_index,
  output logic [CMD_ARG_W-1:0]   cmd_argument,
  output logic                   timeout_enable,
  output logic                   time_out,
  input  logic [RESP_W-1:0]      response,
  input  logic                   command_complete,
  input  logic                   command_index_error,
  input  logic                   ctrl_idle
);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]       RETRY_MAX = 8'(MAX_RETRIES);

  sched_state_t     state;
  logic [CNT_W-1:0] wait_cnt;
  logic [7:0]       retry_cnt;
  logic             last_grant;
  logic             grant_id;
  logic             arb_enable;
  logic [1:0]       arb_grant;

  // Ready is combinational so the handshake completes in the cycle the request is seen.
  assign arb_enable = (state == IDLE) && ctrl_idle && !reset;
  assign req0_ready = arb_grant[0];
  assign req1_ready = arb_grant[1];

  cmd_rr_arbiter u_arbiter (
    .valid      ({req1_valid, req0_valid}),
    .last_grant (last_grant),
    .enable     (arb_enable),
    .grant      (arb_grant)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      wait_cnt       <= '0;
      retry_cnt      <= '0;
      last_grant     <= 1'b1;
      grant_id       <= 1'b0;
      new_command    <= 1'b0;
      time_out       <= 1'b0;
      done0          <= 1'b0;
      done1          <= 1'b0;
      resp_data      <= '0;
      resp_error     <= 1'b0;
      resp_timeout   <= 1'b0;
      cmd_index      <= '0;
      cmd_argument   <= '0;
      timeout_enable <= 1'b0;
    end else begin
      new_command    <= 1'b0;
      time_out       <= 1'b0;
      done0          <= 1'b0;
      done1          <= 1'b0;
      timeout_enable <= timeout_en;
      case (state)
        IDLE: begin
          if (arb_grant != 2'b00) begin
            grant_id     <= arb_grant[1];
            cmd_index    <= arb_grant[1] ? req1_index : req0_index;
            cmd_argument <= arb_grant[1] ? req1_argument : req0_argument;
            retry_cnt    <= '0;
            new_command  <= 1'b1;
            state        <= ISSUE;
          end
        end
        ISSUE: begin
          wait_cnt <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          // Saturating at the last count lets a late timeout_en fire on the next cycle.
          if (wait_cnt != CNT_LAST) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
          if (command_complete) begin
            resp_data    <= response;
            resp_error   <= command_index_error;
            resp_timeout <= 1'b0;
            done0        <= ~grant_id;
            done1        <= grant_id;
            state        <= DONE;
          end else if (timeout_enable && (wait_cnt == CNT_LAST)) begin
            time_out <= 1'b1;
            if (retry_cnt < RETRY_MAX) begin
              retry_cnt <= retry_cnt + 8'd1;
              state     <= GAP;
            end else begin
              resp_data    <= '0;
              resp_error   <= 1'b1;
              resp_timeout <= 1'b1;
              done0        <= ~grant_id;
              done1        <= grant_id;
              state        <= DONE;
            end
          end
        end
        GAP: begin
          if (ctrl_idle) begin
            new_command <= 1'b1;
            state       <= ISSUE;
          end
        end
        DONE: begin
          last_grant <= grant_id;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
